mips_multicycle_ctrl: RTL

- Main control FSM for the multicycle MIPS32 datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states from the 6-bit opcode.
- Drives all datapath enables and mux selects.
- Produces the 2-bit alu_op consumed by the ALU decoder, which combines alu_op with funct to form the 3-bit ALU control.

---
 rtl/mips_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main control FSM for the multicycle MIPS32 datapath. Each instruction is
// walked through fetch, decode, execute, memory and writeback states, chosen
// by the 6-bit opcode. The FSM drives every datapath enable and mux select.
//
// Ports:
//   clk         system clock; all state updates on the rising edge
//   reset       synchronous, active-high; returns the FSM to FETCH
//   op          opcode, instruction register bits [31:26]
//   zero        ALU zero flag, qualifies the beq PC update
//   pc_en       PC load enable = pc_write | (branch & zero)
//   ir_write    instruction register load enable
//   mem_write   memory write enable
//   reg_write   register file write enable
//   iord        memory address select: 0 = PC, 1 = ALUOut
//   alu_src_a   ALU A select: 0 = PC, 1 = register A
//   alu_src_b   ALU B select: 00 = B, 01 = 4, 10 = signext imm, 11 = imm<<2
//   alu_op      00 = add, 01 = subtract, 10 = use funct
//   pc_src      next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
//   reg_dst     write register: 0 = rt, 1 = rd
//   mem_to_reg  writeback data: 0 = ALUOut, 1 = memory data
//   illegal_op  unsupported opcode seen in DECODE
//   state       current state, for debug and verification
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               zero,
    output logic               pc_en,
    output logic               ir_write,
    output logic               mem_write,
    output logic               reg_write,
    output logic               iord,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = STATE_W'(0),
        S_DECODE  = STATE_W'(1),
        S_MEMADR  = STATE_W'(2),
        S_MEMRD   = STATE_W'(3),
        S_MEMWB   = STATE_W'(4),
        S_MEMWR   = STATE_W'(5),
        S_EXECUTE = STATE_W'(6),
        S_ALUWB   = STATE_W'(7),
        S_BRANCH  = STATE_W'(8),
        S_ADDIEX  = STATE_W'(9),
        S_ADDIWB  = STATE_W'(10),
        S_JUMP    = STATE_W'(11)
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   op_legal;
    logic   pc_write;
    logic   branch;

    assign state = state_q;

    assign op_legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                      (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
                else if (op == OP_RTYPE)        state_d = S_EXECUTE;
                else if (op == OP_BEQ)          state_d = S_BRANCH;
                else if (op == OP_ADDI)         state_d = S_ADDIEX;
                else if (op == OP_J)            state_d = S_JUMP;
                else                            state_d = S_FETCH;
            end
            // op is held by the IR until the return to FETCH, so only
            // lw and sw can reach here.
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut.
                alu_src_b  = 2'b11;
                illegal_op = ~op_legal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
            end
        endcase

        // While reset is held, suppress every side effect but present the
        // FETCH mux selects so the datapath sees a clean first cycle.
        if (reset) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
            iord       = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            alu_op     = 2'b00;
            pc_src     = 2'b00;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
        end

        pc_en = pc_write | (branch & zero);
    end

endmodule
